regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Debug read-out engine for the 8-bit accumulator core's 16-entry register file; reads the register file as its other end.
- On a start pulse it requests the shared register-address port from the control unit and walks the selected registers.
- Captures each value from the register file's combinational read output and streams a byte frame (header, register bytes, optional checksum) over a valid/ready interface toward the debug UART.

Parameters:
- NUM_REGS, 16, register-file depth; address width is fixed at 4 bits.
- DATA_W, 8, register and stream byte width.
- REG_MASK, 16'h403F, bit i set means register i is dumped (ACC, A–E, MADDR; ZERO excluded).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to dump one frame.
- busy  out  1  high from the cycle after an accepted start until frame end.
- done  out  1  one-cycle pulse after the last byte is accepted.
- bus_req  out  1  request ownership of the register-file address port.
- bus_gnt  in  1  grant from the control unit; the address port is ours only while high.
- reg_addr  out  4  register address driven to the register file.
- reg_rdata  in  8  combinational register-file read data for reg_addr.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream byte valid.
- tx_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, bus_req and tx_valid are 0; tx_data, reg_addr and the index are 0. Reset mid-frame abandons the frame immediately with no done pulse.
- Handshake: a byte transfers on a clk edge with tx_valid && tx_ready. Once tx_valid is high, tx_valid and tx_data stay stable until accepted.
- IDLE:
  - start=1 → WAIT_GNT; busy=1 and bus_req=1 from the next cycle.
  - start while busy is ignored.
- WAIT_GNT: when bus_gnt=1 → SEND_HDR.
- SEND_HDR:
  - tx_valid=1, tx_data=HEADER.
  - On accept → SCAN with idx=0.
- SCAN:
  - reg_addr=idx.
  - If bus_gnt=0: stall with idx unchanged.
  - Else if REG_MASK[idx]=1: capture reg_rdata into the byte register → SEND_REG.
  - Else if idx==NUM_REGS-1 → END.
  - Else idx++.
  - Exactly one index is examined per cycle.
- SEND_REG:
  - tx_valid=1, tx_data=captured byte.
  - On accept: if idx==NUM_REGS-1 → END; else idx++ → SCAN.
- END: → SEND_CSUM if the feature is enabled, else → FIN.
- FIN:
  - done=1 for one cycle; bus_req and busy drop in the same cycle.
  - → IDLE.
- bus_req stays high continuously from WAIT_GNT through FIN.
- Losing bus_gnt in non-SCAN states has no effect, because the address port is sampled only in SCAN.
- The value is captured in the cycle it is read, so a register-file write in a later cycle does not alter the emitted byte.
- reg_addr holds its last value outside SCAN.
- Frame length is 1 + popcount(REG_MASK) bytes (+1 with checksum). Default: 8 bytes.
- REG_MASK=0: the frame is the header only; the scan still walks all 16 indices.

Optional Feature:
- Macro REGFILE_DUMP_CSUM_EN.
- Defined:
  - An 8-bit running XOR is cleared on start and XORs every accepted byte (header and register bytes).
  - State SEND_CSUM emits it as the last byte with the same handshake, then → FIN.
- Undefined: no checksum state or register; END → FIN directly.

Decomposition:
- Shared package holds:
  - the register-index constants (ACCUMULATOR=0, REGA=1, REGB=2, REGC=3, REGD=4, REGE=5, MADDR=14, ZERO=15);
  - the FSM state encoding (IDLE, WAIT_GNT, SEND_HDR, SCAN, SEND_REG, END, SEND_CSUM, FIN);
  - the HEADER default.
- One natural sub-module: tx_byte_reg, the valid/ready output holding register with stable-until-accepted logic. The FSM, index counter and checksum stay in regfile_dump.

Test Plan:
- Basic dump: load registers 0–5 and 14 with 8'h10–8'h15 and 8'hE0; start; bus_gnt and tx_ready held at 1.
  → bytes A5,10,11,12,13,14,15,E0; done pulses once; bus_req falls with done.
- Backpressure: same stimulus, tx_ready random 30%.
  → identical byte sequence; tx_data never changes while tx_valid high and not accepted.
- Grant stall: drop bus_gnt for 5 cycles while idx=3.
  → SCAN holds, reg_addr stays 3, no byte emitted; resumes with the correct REGC value.
- Start while busy: pulse start mid-frame.
  → ignored; exactly one frame and one done.
- Reset mid-frame: assert rst_n=0 after the 3rd byte.
  → tx_valid, busy and bus_req are 0 immediately, no done; a following start yields a complete frame.
- With REGFILE_DUMP_CSUM_EN defined: all dumped registers 0.
  → final byte A5; a second run with ACC=8'h5A gives final byte FF.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file debug dump engine:
// register indices, FSM encoding and frame defaults.
package regfile_dump_pkg;

    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ACCUMULATOR = 4'd0;
    localparam logic [ADDR_W-1:0] REGA        = 4'd1;
    localparam logic [ADDR_W-1:0] REGB        = 4'd2;
    localparam logic [ADDR_W-1:0] REGC        = 4'd3;
    localparam logic [ADDR_W-1:0] REGD        = 4'd4;
    localparam logic [ADDR_W-1:0] REGE        = 4'd5;
    localparam logic [ADDR_W-1:0] MADDR       = 4'd14;
    localparam logic [ADDR_W-1:0] ZERO        = 4'd15;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Architectural registers worth dumping; ZERO is hardwired so it is skipped.
    localparam logic [15:0] MASK_DEFAULT =
        (16'd1 << ACCUMULATOR) | (16'd1 << REGA) | (16'd1 << REGB) |
        (16'd1 << REGC) | (16'd1 << REGD) | (16'd1 << REGE) |
        (16'd1 << MADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GNT,
        S_SEND_HDR,
        S_SCAN,
        S_SEND_REG,
        S_END,
        S_SEND_CSUM,
        S_FIN
    } state_t;

endpackage

// File: rtl/regfile_dump_tx_byte_reg.sv
// Valid/ready output holding register: a loaded byte stays on
// tx_data with tx_valid high until the downstream accepts it.
module tx_byte_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks REG_MASK and streams a byte frame.
// Define REGFILE_DUMP_CSUM_EN to append an XOR checksum byte.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int                 NUM_REGS = 16,
    parameter int                 DATA_W   = 8,
    parameter logic [15:0]        REG_MASK = MASK_DEFAULT,
    parameter logic [DATA_W-1:0]  HEADER   = HEADER_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [3:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [3:0]        idx;
    logic              idx_clr, idx_inc;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              accept;
    logic              last;

    assign accept   = tx_valid && tx_ready;
    assign last     = (idx == LAST_IDX);
    assign reg_addr = idx;
    assign busy     = (state != S_IDLE);
    assign bus_req  = (state != S_IDLE);
    assign done     = (state == S_FIN);

`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == S_IDLE && start) begin
            csum <= '0;
        end else if (accept && state != S_SEND_CSUM) begin
            csum <= csum ^ tx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (idx_clr) begin
            idx <= '0;
        end else if (idx_inc) begin
            idx <= idx + 4'd1;
        end
    end

    always_comb begin
        state_n   = state;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        load      = 1'b0;
        load_data = HEADER;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_WAIT_GNT;
            end
            S_WAIT_GNT: begin
                if (bus_gnt) begin
                    load    = 1'b1;
                    state_n = S_SEND_HDR;
                end
            end
            S_SEND_HDR: begin
                if (accept) begin
                    idx_clr = 1'b1;
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                // The address port is only trusted while granted.
                if (bus_gnt) begin
                    if (REG_MASK[idx]) begin
                        load      = 1'b1;
                        load_data = reg_rdata;
                        state_n   = S_SEND_REG;
                    end else if (last) begin
                        state_n = S_END;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            S_SEND_REG: begin
                if (accept) begin
                    if (last) begin
                        state_n = S_END;
                    end else begin
                        idx_inc = 1'b1;
                        state_n = S_SCAN;
                    end
                end
            end
            S_END: begin
`ifdef REGFILE_DUMP_CSUM_EN
                load      = 1'b1;
                load_data = csum;
                state_n   = S_SEND_CSUM;
`else
                state_n = S_FIN;
`endif
            end
            S_SEND_CSUM: begin
`ifdef REGFILE_DUMP_CSUM_EN
                if (accept) state_n = S_FIN;
`else
                state_n = S_IDLE;
`endif
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    tx_byte_reg #(
        .DATA_W(DATA_W)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: frame model from register contents,
// per-cycle stream checks and directed scenarios.
module tb_regfile_dump;

    localparam logic [15:0] MASK = 16'h403F;
    localparam logic [7:0]  HDR  = 8'hA5;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       bus_req;
    logic       bus_gnt;
    logic [3:0] reg_addr;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic [7:0] rf [16];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    logic [7:0] lit [8];

    int   ncheck = 0;
    int   nerr   = 0;
    int   nacc   = 0;
    int   ndone  = 0;
    bit   bp_en  = 0;
    bit   hold_prev = 0;
    bit   prev_done = 0;
    logic [7:0] hold_data = '0;

    assign reg_rdata = rf[reg_addr];

    regfile_dump dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .reg_addr (reg_addr),
        .reg_rdata(reg_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name,
                       input int act, input int req);
        ncheck++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Frame = header, every masked register in index order, optional XOR.
    task automatic build_frame();
        logic [7:0] x;
        exp_q.delete();
        got.delete();
        exp_q.push_back(HDR);
        x = HDR;
        for (int i = 0; i < 16; i++) begin
            if (MASK[i]) begin
                exp_q.push_back(rf[i]);
                x = x ^ rf[i];
            end
        end
`ifdef REGFILE_DUMP_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 0;
            prev_done = 0;
        end else begin
            if (hold_prev) begin
                chk(tx_valid == 1'b1, "hold_valid", tx_valid, 1);
                chk(tx_data == hold_data, "hold_data", tx_data, hold_data);
            end
            chk(bus_req == busy, "req_eq_busy", bus_req, busy);
            if (tx_valid && tx_ready) begin
                chk(exp_q.size() != 0, "extra_byte", tx_data, 0);
                if (exp_q.size() != 0) begin
                    chk(tx_data == exp_q[0], "stream_byte",
                        tx_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got.push_back(tx_data);
                nacc++;
            end
            if (done) begin
                ndone++;
                chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
                chk(bus_req == 1'b1, "req_with_done", bus_req, 1);
            end
            if (prev_done) begin
                chk(bus_req == 1'b0, "req_fall", bus_req, 0);
                chk(done == 1'b0, "done_one_cycle", done, 0);
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
            prev_done = done;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int k = 0; k < 2000 && ndone == prev; k++) @(posedge clk);
        chk(ndone == prev + 1, "done_seen", ndone, prev + 1);
    endtask

    task automatic wait_acc(input int target);
        for (int k = 0; k < 2000 && nacc < target; k++) @(posedge clk);
        chk(nacc >= target, "acc_reached", nacc, target);
    endtask

    task automatic run_frame();
        int prev;
        build_frame();
        prev = ndone;
        pulse_start();
        wait_done(prev);
        repeat (2) @(negedge clk);
        chk(busy == 1'b0, "idle_busy", busy, 0);
        chk(got.size() == FLEN, "frame_len", got.size(), FLEN);
    endtask

    initial begin
        int prev;
        int base;
        rst_n   = 1'b0;
        start   = 1'b0;
        bus_gnt = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        lit = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hE0};

        repeat (2) @(negedge clk);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(bus_req == 0, "rst_req", bus_req, 0);
        chk(tx_valid == 0, "rst_valid", tx_valid, 0);
        chk(tx_data == 0, "rst_data", tx_data, 0);
        chk(reg_addr == 0, "rst_addr", reg_addr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic dump with a distinctive value per register.
        for (int i = 0; i < 6; i++) rf[i] = 8'(8'h10 + i);
        rf[14] = 8'hE0;
        rf[6]  = 8'h66;
        rf[15] = 8'hFF;
        run_frame();
        for (int i = 0; i < 8; i++)
            if (i < got.size())
                chk(got[i] == lit[i], "basic_lit", got[i], lit[i]);

        // Same registers under random backpressure.
        bp_en = 1;
        run_frame();
        bp_en = 0;
        for (int i = 0; i < 8; i++)
            if (i < got.size())
                chk(got[i] == lit[i], "bp_lit", got[i], lit[i]);

        // Grant withdrawn while the scan sits on REGC.
        rf[0] = 8'h81; rf[1] = 8'h42; rf[2] = 8'h24; rf[3] = 8'h9C;
        rf[4] = 8'hC3; rf[5] = 8'h7E; rf[14] = 8'h5A;
        build_frame();
        base = nacc;
        prev = ndone;
        pulse_start();
        wait_acc(base + 4);
        #1 bus_gnt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk(reg_addr == 4'd3, "stall_addr", reg_addr, 3);
            chk(tx_valid == 1'b0, "stall_valid", tx_valid, 0);
            chk(busy == 1'b1, "stall_busy", busy, 1);
        end
        @(posedge clk);
        #1 bus_gnt = 1'b1;
        wait_done(prev);
        chk(got.size() == FLEN, "stall_len", got.size(), FLEN);
        if (got.size() > 4)
            chk(got[4] == 8'h9C, "stall_regc", got[4], 8'h9C);

        // A second start in mid-frame must be ignored.
        build_frame();
        base = nacc;
        prev = ndone;
        pulse_start();
        wait_acc(base + 3);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(prev);
        repeat (30) @(negedge clk);
        chk(ndone == prev + 1, "one_done", ndone, prev + 1);
        chk(busy == 1'b0, "no_refire", busy, 0);
        chk(nacc == base + FLEN, "one_frame", nacc - base, FLEN);

        // Reset after the third byte abandons the frame.
        build_frame();
        base = nacc;
        prev = ndone;
        pulse_start();
        wait_acc(base + 3);
        #1 rst_n = 1'b0;
        #1;
        chk(tx_valid == 1'b0, "mid_rst_valid", tx_valid, 0);
        chk(busy == 1'b0, "mid_rst_busy", busy, 0);
        chk(bus_req == 1'b0, "mid_rst_req", bus_req, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk(ndone == prev, "mid_rst_no_done", ndone, prev);
        run_frame();

`ifdef REGFILE_DUMP_CSUM_EN
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        run_frame();
        if (got.size() == FLEN)
            chk(got[FLEN-1] == 8'hA5, "csum_zero", got[FLEN-1], 8'hA5);
        rf[0] = 8'h5A;
        run_frame();
        if (got.size() == FLEN)
            chk(got[FLEN-1] == 8'hFF, "csum_acc", got[FLEN-1], 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 ncheck, nerr);
        $finish;
    end

endmodule
